// File: rtl/kgp_risc_mc_ctrl_pkg.sv
// Shared types and constants for the KGP_RISC multi-cycle sequencer and its decoder.
package kgp_risc_mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_ILLEGAL,
        ST_FAULT
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU_R,
        CL_ALU_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_HALT,
        CL_UNDEF
    } class_e;

    localparam logic [5:0] OP_ALU_R  = 6'h00;
    localparam logic [5:0] OP_ALU_I  = 6'h01;
    localparam logic [5:0] OP_LOAD   = 6'h02;
    localparam logic [5:0] OP_STORE  = 6'h03;
    localparam logic [5:0] OP_BRANCH = 6'h04;
    localparam logic [5:0] OP_JUMP   = 6'h05;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;

    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] REGDST_RT  = 2'd0;
    localparam logic [1:0] REGDST_RD  = 2'd1;
    localparam logic [1:0] ALUSRC_REG = 2'd0;
    localparam logic [1:0] ALUSRC_IMM = 2'd1;
    localparam logic [1:0] M2R_ALU    = 2'd0;
    localparam logic [1:0] M2R_MEM    = 2'd1;

    function automatic logic is_mem_class(class_e c);
        return (c == CL_LOAD) || (c == CL_STORE);
    endfunction

endpackage

// File: rtl/kgp_risc_mc_ctrl_decode.sv
// Combinational opcode/funccode decoder: instruction class plus the ALU-side controls.
module kgp_risc_mc_ctrl_decode
    import kgp_risc_mc_ctrl_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int FN_W  = 6
) (
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [FN_W-1:0]  funccode_i,
    output logic [2:0]       cls_o,
    output logic [2:0]       aluop_o,
    output logic [1:0]       reg_dest_o,
    output logic [1:0]       alu_src_o
);

    class_e cls;

    // Only the low three funccode bits select the ALU operation.
    logic unused_fn;
    assign unused_fn = ^funccode_i[FN_W-1:3];

    always_comb begin
        cls        = CL_UNDEF;
        aluop_o    = ALUOP_ADD;
        reg_dest_o = REGDST_RT;
        alu_src_o  = ALUSRC_REG;
        case (opcode_i)
            OPC_W'(OP_ALU_R): begin
                cls        = CL_ALU_R;
                aluop_o    = funccode_i[2:0];
                reg_dest_o = REGDST_RD;
            end
            OPC_W'(OP_ALU_I): begin
                cls       = CL_ALU_I;
                aluop_o   = funccode_i[2:0];
                alu_src_o = ALUSRC_IMM;
            end
            OPC_W'(OP_LOAD): begin
                cls       = CL_LOAD;
                alu_src_o = ALUSRC_IMM;
            end
            OPC_W'(OP_STORE): begin
                cls       = CL_STORE;
                alu_src_o = ALUSRC_IMM;
            end
            OPC_W'(OP_BRANCH): begin
                cls     = CL_BRANCH;
                aluop_o = ALUOP_SUB;
            end
            OPC_W'(OP_JUMP): cls = CL_JUMP;
            OPC_W'(OP_HALT): cls = CL_HALT;
            default:         cls = CL_UNDEF;
        endcase
    end

    assign cls_o = cls;

endmodule

// File: rtl/kgp_risc_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack memory and retired-instruction count.
// Define KGP_MC_TIMEOUT_EN to add the memory-ack timeout and the sticky bus_fault state.
module kgp_risc_mc_ctrl
    import kgp_risc_mc_ctrl_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int FN_W  = 6,
    parameter int CNT_W = 32
`ifdef KGP_MC_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 255
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [FN_W-1:0]  funccode_i,
    input  logic             br_taken_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_instr_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dest_o,
    output logic [1:0]       ALUsource_o,
    output logic [2:0]       ALUop_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             halted_o,
    output logic             illegal_o,
    output logic             bus_fault_o,
    output logic [CNT_W-1:0] instret_o
);

    logic [2:0] dec_cls;
    logic [2:0] dec_aluop;
    logic [1:0] dec_dst;
    logic [1:0] dec_src;

    kgp_risc_mc_ctrl_decode #(
        .OPC_W(OPC_W),
        .FN_W (FN_W)
    ) u_decode (
        .opcode_i  (opcode_i),
        .funccode_i(funccode_i),
        .cls_o     (dec_cls),
        .aluop_o   (dec_aluop),
        .reg_dest_o(dec_dst),
        .alu_src_o (dec_src)
    );

    state_e           state_q, state_d;
    class_e           lat_cls_q, lat_cls_d;
    logic [2:0]       lat_op_q, lat_op_d;
    logic [1:0]       lat_dst_q, lat_dst_d;
    logic [1:0]       lat_src_q, lat_src_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic       mem_req_q, mem_req_d;
    logic       mem_we_q, mem_we_d;
    logic       mem_instr_q, mem_instr_d;
    logic       reg_write_q, reg_write_d;
    logic [1:0] reg_dest_q, reg_dest_d;
    logic [1:0] alu_src_q, alu_src_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic [1:0] mem_to_reg_q, mem_to_reg_d;
    logic       halted_q, halted_d;
    logic       illegal_q, illegal_d;

`ifdef KGP_MC_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;
    logic       bus_fault_q, bus_fault_d;
`endif

    // An ack only counts while a request is actually outstanding.
    logic ack;
    assign ack = mem_ack_i & mem_req_q;

    always_comb begin
        state_d   = state_q;
        lat_cls_d = lat_cls_q;
        lat_op_d  = lat_op_q;
        lat_dst_d = lat_dst_q;
        lat_src_d = lat_src_q;
        if (state_q == ST_DECODE) begin
            lat_cls_d = class_e'(dec_cls);
            lat_op_d  = dec_aluop;
            lat_dst_d = dec_dst;
            lat_src_d = dec_src;
        end

        case (state_q)
            ST_FETCH:  if (ack) state_d = ST_DECODE;
            ST_DECODE: begin
                case (lat_cls_d)
                    CL_HALT:  state_d = ST_HALT;
                    CL_UNDEF: state_d = ST_ILLEGAL;
                    default:  state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (lat_cls_q == CL_ALU_R || lat_cls_q == CL_ALU_I) state_d = ST_WB;
                else if (is_mem_class(lat_cls_q))                  state_d = ST_MEM;
                else                                               state_d = ST_FETCH;
            end
            ST_MEM:    if (ack) state_d = (lat_cls_q == CL_STORE) ? ST_FETCH : ST_WB;
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = state_q;
        endcase

`ifdef KGP_MC_TIMEOUT_EN
        wait_d = '0;
        if ((state_q == ST_FETCH || state_q == ST_MEM) && mem_req_q && !ack) begin
            wait_d = wait_q + 8'd1;
            if (wait_d == 8'(TMO_CYC)) state_d = ST_FAULT;
        end
`endif

        instret_d = instret_q;
        if (state_q != ST_FETCH && state_d == ST_FETCH) instret_d = instret_q + CNT_W'(1);

        // Registered Moore outputs are decoded from the state being entered.
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_instr_d  = 1'b0;
        reg_write_d  = 1'b0;
        reg_dest_d   = REGDST_RT;
        alu_src_d    = ALUSRC_REG;
        alu_op_d     = ALUOP_ADD;
        mem_to_reg_d = M2R_ALU;
        halted_d     = 1'b0;
        illegal_d    = 1'b0;
`ifdef KGP_MC_TIMEOUT_EN
        bus_fault_d  = 1'b0;
`endif
        if (state_d == ST_EXEC || state_d == ST_MEM || state_d == ST_WB) begin
            reg_dest_d = lat_dst_d;
            alu_src_d  = lat_src_d;
            alu_op_d   = lat_op_d;
        end
        case (state_d)
            ST_FETCH: begin
                mem_req_d   = 1'b1;
                mem_instr_d = 1'b1;
            end
            ST_MEM: begin
                mem_req_d = 1'b1;
                mem_we_d  = (lat_cls_d == CL_STORE);
            end
            ST_WB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = (lat_cls_d == CL_LOAD) ? M2R_MEM : M2R_ALU;
            end
            ST_HALT:    halted_d  = 1'b1;
            ST_ILLEGAL: illegal_d = 1'b1;
`ifdef KGP_MC_TIMEOUT_EN
            ST_FAULT:   bus_fault_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_FETCH;
            lat_cls_q    <= CL_ALU_R;
            lat_op_q     <= '0;
            lat_dst_q    <= '0;
            lat_src_q    <= '0;
            instret_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_instr_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_dest_q   <= '0;
            alu_src_q    <= '0;
            alu_op_q     <= '0;
            mem_to_reg_q <= '0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
`ifdef KGP_MC_TIMEOUT_EN
            wait_q       <= '0;
            bus_fault_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lat_cls_q    <= lat_cls_d;
            lat_op_q     <= lat_op_d;
            lat_dst_q    <= lat_dst_d;
            lat_src_q    <= lat_src_d;
            instret_q    <= instret_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_instr_q  <= mem_instr_d;
            reg_write_q  <= reg_write_d;
            reg_dest_q   <= reg_dest_d;
            alu_src_q    <= alu_src_d;
            alu_op_q     <= alu_op_d;
            mem_to_reg_q <= mem_to_reg_d;
            halted_q     <= halted_d;
            illegal_q    <= illegal_d;
`ifdef KGP_MC_TIMEOUT_EN
            wait_q       <= wait_d;
            bus_fault_q  <= bus_fault_d;
`endif
        end
    end

    // PC/IR strobes follow the ack and the branch flag within the same cycle.
    logic exec_jump, exec_taken;
    assign exec_jump  = (state_q == ST_EXEC) && (lat_cls_q == CL_JUMP);
    assign exec_taken = (state_q == ST_EXEC) && (lat_cls_q == CL_BRANCH) && br_taken_i;

    assign ir_write_o   = (state_q == ST_FETCH) && ack;
    assign pc_write_o   = ir_write_o || exec_jump || exec_taken;
    assign pc_src_o     = exec_jump ? PCSRC_JUMP : (exec_taken ? PCSRC_BRANCH : PCSRC_SEQ);

    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_instr_o  = mem_instr_q;
    assign reg_write_o  = reg_write_q;
    assign reg_dest_o   = reg_dest_q;
    assign ALUsource_o  = alu_src_q;
    assign ALUop_o      = alu_op_q;
    assign mem_to_reg_o = mem_to_reg_q;
    assign halted_o     = halted_q;
    assign illegal_o    = illegal_q;
    assign instret_o    = instret_q;
`ifdef KGP_MC_TIMEOUT_EN
    assign bus_fault_o  = bus_fault_q;
`else
    assign bus_fault_o  = 1'b0;
`endif

endmodule

// File: tb/tb_kgp_risc_mc_ctrl.sv
// Self-checking bench for kgp_risc_mc_ctrl: directed and randomized instructions against a per-instruction model.
// Builds the fault/timeout scenario when KGP_MC_TIMEOUT_EN is defined.
module tb_kgp_risc_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funccode;
    logic        br_taken;
    logic        mem_ack;
    logic        mem_req_o, mem_we_o, mem_instr_o, ir_write_o, pc_write_o;
    logic [1:0]  pc_src_o;
    logic        reg_write_o;
    logic [1:0]  reg_dest_o, ALUsource_o, mem_to_reg_o;
    logic [2:0]  ALUop_o;
    logic        halted_o, illegal_o, bus_fault_o;
    logic [31:0] instret_o;

    int total = 0;
    int bad = 0;
    int expCnt = 0;

    always #5 clk = ~clk;

    kgp_risc_mc_ctrl #(
        .OPC_W(6),
        .FN_W (6),
        .CNT_W(32)
`ifdef KGP_MC_TIMEOUT_EN
        ,
        .TMO_CYC(8)
`endif
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .opcode_i    (opcode),
        .funccode_i  (funccode),
        .br_taken_i  (br_taken),
        .mem_ack_i   (mem_ack),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_instr_o (mem_instr_o),
        .ir_write_o  (ir_write_o),
        .pc_write_o  (pc_write_o),
        .pc_src_o    (pc_src_o),
        .reg_write_o (reg_write_o),
        .reg_dest_o  (reg_dest_o),
        .ALUsource_o (ALUsource_o),
        .ALUop_o     (ALUop_o),
        .mem_to_reg_o(mem_to_reg_o),
        .halted_o    (halted_o),
        .illegal_o   (illegal_o),
        .bus_fault_o (bus_fault_o),
        .instret_o   (instret_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench sampled inside the first FETCH request cycle.
    task automatic syncFetch(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req_o && mem_instr_o) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(found), 32'd1);
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        mem_ack = 1'b0;
        #1;
        checkOutput("rst_outputs", 32'({mem_req_o, mem_we_o, mem_instr_o, ir_write_o, pc_write_o,
                    pc_src_o, reg_write_o, reg_dest_o, ALUsource_o, ALUop_o, mem_to_reg_o,
                    halted_o, illegal_o, bus_fault_o}), 32'd0);
        checkOutput("rst_instret", instret_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        expCnt = 0;
        syncFetch("fetch_after_reset");
    endtask

    // Runs one instruction from its first FETCH cycle; fw/mw are ack wait cycles for fetch/memory.
    task automatic applyStimulus(input logic [5:0] opc, input logic [5:0] fn, input logic bt,
                                 input int fw, input int mw);
        int lat = 0, expRw = 0, expDst = 0, expM2r = 0, expOp = 0, expSrc = 0;
        int expPcw = 0, expPcSrc = 0, expWe = 0;
        int irCyc = -1, fetchPc = 0, rwCnt = 0, rwCyc = -1, dstSeen = 0, m2rSeen = 0;
        int opSeen = -1, srcSeen = -1, pcwCnt = 0, pcSrcSeen = 0, weCnt = 0, reqCyc = 0;
        opcode   = opc;
        funccode = fn;
        br_taken = bt;
        case (opc)
            6'h00: begin lat = 4 + fw; expRw = 1; expDst = 1; expOp = int'(fn[2:0]); end
            6'h01: begin lat = 4 + fw; expRw = 1; expSrc = 1; expOp = int'(fn[2:0]); end
            6'h02: begin lat = 5 + fw + mw; expRw = 1; expM2r = 1; expSrc = 1; end
            6'h03: begin lat = 4 + fw + mw; expSrc = 1; expWe = mw + 1; end
            6'h04: begin lat = 3 + fw; expOp = 1; expPcw = int'(bt); expPcSrc = bt ? 1 : 0; end
            6'h05: begin lat = 3 + fw; expPcw = 1; expPcSrc = 2; end
            default: lat = 1;
        endcase
        for (int cyc = 1; cyc <= lat; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
            end
            if (mem_req_o) begin
                reqCyc++;
                if (reqCyc > (mem_instr_o ? fw : mw)) begin
                    mem_ack = 1'b1;
                    reqCyc  = 0;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            if (ir_write_o) begin
                irCyc   = cyc;
                fetchPc = (pc_write_o && pc_src_o == 2'd0) ? 1 : 0;
            end else if (pc_write_o) begin
                pcwCnt++;
                pcSrcSeen = int'(pc_src_o);
            end
            if (reg_write_o) begin
                rwCnt++;
                rwCyc   = cyc;
                dstSeen = int'(reg_dest_o);
                m2rSeen = int'(mem_to_reg_o);
            end
            if (mem_we_o) weCnt++;
            if (cyc == fw + 3) begin
                opSeen  = int'(ALUop_o);
                srcSeen = int'(ALUsource_o);
            end
        end
        checkOutput("ir_write_cycle", 32'(irCyc), 32'(fw + 1));
        checkOutput("fetch_pc_seq", 32'(fetchPc), 32'd1);
        checkOutput("exec_aluop", 32'(opSeen), 32'(expOp));
        checkOutput("exec_alusrc", 32'(srcSeen), 32'(expSrc));
        checkOutput("reg_write_count", 32'(rwCnt), 32'(expRw));
        if (expRw != 0) begin
            checkOutput("reg_write_cycle", 32'(rwCyc), 32'(lat));
            checkOutput("reg_dest", 32'(dstSeen), 32'(expDst));
            checkOutput("mem_to_reg", 32'(m2rSeen), 32'(expM2r));
        end
        checkOutput("pc_write_count", 32'(pcwCnt), 32'(expPcw));
        checkOutput("pc_src", 32'(pcSrcSeen), 32'(expPcSrc));
        checkOutput("mem_we_cycles", 32'(weCnt), 32'(expWe));
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        expCnt++;
        checkOutput("next_fetch", 32'({mem_req_o, mem_instr_o}), 32'd3);
        checkOutput("instret", instret_o, 32'(expCnt));
    endtask

    task automatic checkStop(input logic [5:0] opc, input logic isHalt);
        int reqSeen = 0, strobeSeen = 0;
        opcode  = opc;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("stop_flag", 32'(isHalt ? halted_o : illegal_o), 32'd1);
        checkOutput("stop_other_flag", 32'(isHalt ? illegal_o : halted_o), 32'd0);
        for (int i = 0; i < 20; i++) begin
            mem_ack  = 1'($urandom_range(0, 1));
            br_taken = 1'b1;
            #1;
            if (mem_req_o) reqSeen++;
            if (ir_write_o || pc_write_o || reg_write_o || mem_we_o) strobeSeen++;
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        checkOutput("stop_no_req", 32'(reqSeen), 32'd0);
        checkOutput("stop_no_strobe", 32'(strobeSeen), 32'd0);
        checkOutput("stop_sticky", 32'(isHalt ? halted_o : illegal_o), 32'd1);
        checkOutput("stop_instret", instret_o, 32'(expCnt));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [5:0] ops [6];
        logic [5:0] rop;
        int reqs;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
        rst_n    = 1'b0;
        opcode   = '0;
        funccode = '0;
        br_taken = 1'b0;
        mem_ack  = 1'b0;
        doReset();

        applyStimulus(6'h00, 6'h02, 1'b0, 0, 0);
        applyStimulus(6'h02, 6'h00, 1'b0, 3, 3);
        applyStimulus(6'h04, 6'h00, 1'b1, 0, 0);
        applyStimulus(6'h04, 6'h00, 1'b0, 0, 0);
        applyStimulus(6'h03, 6'h00, 1'b0, 0, 0);
        applyStimulus(6'h05, 6'h00, 1'b1, 1, 0);

        for (int n = 0; n < 24; n++) begin
            rop = ops[$urandom_range(0, 5)];
            applyStimulus(rop, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Store interrupted by reset while its memory request is outstanding.
        opcode  = 6'h03;
        mem_ack = 1'b1;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("mem_store_req", 32'({mem_req_o, mem_instr_o, mem_we_o}), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midmem_req_we", 32'({mem_req_o, mem_we_o}), 32'd0);
        checkOutput("midmem_instret", instret_o, 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        expCnt = 0;
        syncFetch("restart_fetch");
        applyStimulus(6'h01, 6'h05, 1'b0, 2, 0);

        checkStop(6'h3F, 1'b1);
        doReset();
        applyStimulus(6'h00, 6'h07, 1'b0, 0, 0);
        checkStop(6'h2A, 1'b0);
        doReset();

`ifdef KGP_MC_TIMEOUT_EN
        mem_ack = 1'b0;
        reqs = 1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (mem_req_o) reqs++;
            else break;
        end
        checkOutput("timeout_req_cycles", 32'(reqs), 32'd8);
        checkOutput("bus_fault", 32'({bus_fault_o, mem_req_o}), 32'd2);
        doReset();
`else
        reqs = 0;
        mem_ack = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (mem_req_o) reqs++;
        end
        checkOutput("no_timeout_wait", 32'(reqs), 32'd30);
        checkOutput("bus_fault_tied", 32'(bus_fault_o), 32'd0);
        doReset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
